// File: rtl/urv_imem_bridge_if.sv
// Pipelined Wishbone-style instruction bus between urv_imem_bridge (master)
// and the instruction memory or slave fabric.
interface urv_imem_bridge_if;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic        stall;
  logic        ack;
  logic [31:0] dat;

  modport master (output cyc, stb, adr, input stall, ack, dat);
  modport slave  (input cyc, stb, adr, output stall, ack, dat);
endinterface

// File: rtl/urv_imem_bridge.sv
// Instruction-side bridge from urv_fetch to a single-outstanding pipelined bus.
// Optional one-entry hit buffer enabled by defining URV_IMEM_HIT_BUF_EN.
module urv_imem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [31:0]              im_addr_i,
  input  logic                     im_flush_i,
  output logic [31:0]              im_data_o,
  output logic                     im_valid_o,
  output logic                     im_timeout_o,
  urv_imem_bridge_if.master        ib
);

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e           state_q, state_d;
  logic [29:0]      req_addr_q, req_addr_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             cyc, stb;
  logic [31:0]      adr;
  logic             hit;
  logic             deliver;
  logic             unused_inputs;

`ifdef URV_IMEM_HIT_BUF_EN
  logic             hb_valid_q, hb_valid_d;
  logic [29:0]      hb_addr_q, hb_addr_d;
  logic [31:0]      hb_data_q, hb_data_d;

  assign hit = hb_valid_q && (im_addr_i[31:2] == hb_addr_q) && !im_flush_i;
  assign unused_inputs = ^im_addr_i[1:0];
`else
  assign hit = 1'b0;
  assign unused_inputs = ^{im_flush_i, im_addr_i[1:0]};
`endif

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    tmo_cnt_d  = tmo_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;
    cyc        = 1'b0;
    stb        = 1'b0;
    adr        = {req_addr_q, 2'b00};
    deliver    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit) begin
`ifdef URV_IMEM_HIT_BUF_EN
          data_d  = hb_data_q;
`endif
          valid_d = 1'b1;
        end else begin
          cyc = 1'b1;
          stb = 1'b1;
          adr = {im_addr_i[31:2], 2'b00};
          if (!ib.stall) begin
            req_addr_d = im_addr_i[31:2];
            tmo_cnt_d  = '0;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        cyc = 1'b1;
        // A redirected fetch address means the returning word is stale.
        if (ib.ack) begin
          state_d = IDLE;
          if (im_addr_i[31:2] == req_addr_q) begin
            data_d  = ib.dat;
            valid_d = 1'b1;
            deliver = 1'b1;
          end
        end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (tmo_cnt_q != '1) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef URV_IMEM_HIT_BUF_EN
  always_comb begin
    hb_valid_d = hb_valid_q;
    hb_addr_d  = hb_addr_q;
    hb_data_d  = hb_data_q;
    if (deliver) begin
      hb_valid_d = 1'b1;
      hb_addr_d  = req_addr_q;
      hb_data_d  = ib.dat;
    end
    if (im_flush_i) hb_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hb_valid_q <= 1'b0;
      hb_addr_q  <= '0;
      hb_data_q  <= '0;
    end else begin
      hb_valid_q <= hb_valid_d;
      hb_addr_q  <= hb_addr_d;
      hb_data_q  <= hb_data_d;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      tmo_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      tmo_cnt_q  <= tmo_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  // Gating with reset keeps the bus quiet while reset is asserted, even in IDLE.
  assign ib.cyc       = cyc & rst_n_i;
  assign ib.stb       = stb & rst_n_i;
  assign ib.adr       = adr;
  assign im_data_o    = data_q;
  assign im_valid_o   = valid_q;
  assign im_timeout_o = timeout_q;

endmodule

// File: tb/tb_urv_imem_bridge.sv
// Table-driven bench for urv_imem_bridge (TIMEOUT_CYCLES=4) with hand-written
// reset and hit-buffer sequences.
module tb_urv_imem_bridge;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [31:0] im_addr_i;
  logic        im_flush_i;
  logic [31:0] im_data_o;
  logic        im_valid_o;
  logic        im_timeout_o;
  int          errors = 0;
  int          checks = 0;

  urv_imem_bridge_if ib ();

  urv_imem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .im_addr_i    (im_addr_i),
    .im_flush_i   (im_flush_i),
    .im_data_o    (im_data_o),
    .im_valid_o   (im_valid_o),
    .im_timeout_o (im_timeout_o),
    .ib           (ib.master)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        stall;
    logic        ack;
    logic [31:0] dat;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic        valid;
    logic [31:0] data;
    logic        tmo;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [31:0] a, input logic s, input logic k,
                              input logic [31:0] d, input logic c, input logic b,
                              input logic [31:0] ad, input logic v,
                              input logic [31:0] dt, input logic t);
    vec_t r;
    r.addr = a; r.stall = s; r.ack = k; r.dat = d;
    r.cyc = c; r.stb = b; r.adr = ad; r.valid = v; r.data = dt; r.tmo = t;
    return r;
  endfunction

  // Advance one clock and drive this cycle's inputs just after the edge.
  task automatic applyStimulus(input logic [31:0] a, input logic f, input logic s,
                               input logic k, input logic [31:0] d);
    @(posedge clk_i);
    #1;
    im_addr_i  = a;
    im_flush_i = f;
    ib.stall   = s;
    ib.ack     = k;
    ib.dat     = d;
  endtask

  task automatic checkOutput(input string name, input logic ecyc, input logic estb,
                             input bit chk_adr, input logic [31:0] eadr,
                             input logic evalid, input logic [31:0] edata,
                             input logic etmo);
    logic ok;
    checks++;
    ok = (ib.cyc === ecyc) && (ib.stb === estb) && (im_valid_o === evalid) &&
         (im_data_o === edata) && (im_timeout_o === etmo) &&
         (!chk_adr || (ib.adr === eadr));
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got cyc=%b stb=%b adr=%h valid=%b data=%h tmo=%b, expected cyc=%b stb=%b adr=%h valid=%b data=%h tmo=%b",
               name, ib.cyc, ib.stb, ib.adr, im_valid_o, im_data_o, im_timeout_o,
               ecyc, estb, eadr, evalid, edata, etmo);
    end
  endtask

  initial begin
    //                 addr      stl ack dat           cyc stb adr       vld data          tmo
    tbl[0]  = mk(32'h100, 0, 0, 32'h0,        1, 1, 32'h100, 0, 32'h0,        0);
    tbl[1]  = mk(32'h100, 0, 1, 32'h13,       1, 0, 32'h100, 0, 32'h0,        0);
    tbl[2]  = mk(32'h104, 1, 0, 32'h0,        1, 1, 32'h104, 1, 32'h13,       0);
    tbl[3]  = mk(32'h200, 1, 0, 32'h0,        1, 1, 32'h200, 0, 32'h13,       0);
    tbl[4]  = mk(32'h200, 1, 0, 32'h0,        1, 1, 32'h200, 0, 32'h13,       0);
    tbl[5]  = mk(32'h200, 1, 0, 32'h0,        1, 1, 32'h200, 0, 32'h13,       0);
    tbl[6]  = mk(32'h200, 0, 0, 32'h0,        1, 1, 32'h200, 0, 32'h13,       0);
    tbl[7]  = mk(32'h200, 0, 0, 32'h0,        1, 0, 32'h200, 0, 32'h13,       0);
    tbl[8]  = mk(32'h200, 0, 1, 32'hAABBCCDD, 1, 0, 32'h200, 0, 32'h13,       0);
    tbl[9]  = mk(32'h100, 0, 0, 32'h0,        1, 1, 32'h100, 1, 32'hAABBCCDD, 0);
    tbl[10] = mk(32'h400, 0, 0, 32'h0,        1, 0, 32'h100, 0, 32'hAABBCCDD, 0);
    tbl[11] = mk(32'h400, 0, 1, 32'hDEADBEEF, 1, 0, 32'h100, 0, 32'hAABBCCDD, 0);
    tbl[12] = mk(32'h400, 0, 0, 32'h0,        1, 1, 32'h400, 0, 32'hAABBCCDD, 0);
    tbl[13] = mk(32'h400, 0, 1, 32'h11111111, 1, 0, 32'h400, 0, 32'hAABBCCDD, 0);
    tbl[14] = mk(32'h500, 0, 0, 32'h0,        1, 1, 32'h500, 1, 32'h11111111, 0);
    tbl[15] = mk(32'h500, 0, 0, 32'h0,        1, 0, 32'h500, 0, 32'h11111111, 0);
    tbl[16] = mk(32'h500, 0, 0, 32'h0,        1, 0, 32'h500, 0, 32'h11111111, 0);
    tbl[17] = mk(32'h500, 0, 0, 32'h0,        1, 0, 32'h500, 0, 32'h11111111, 0);
    tbl[18] = mk(32'h500, 0, 0, 32'h0,        1, 0, 32'h500, 0, 32'h11111111, 0);
    tbl[19] = mk(32'h500, 1, 0, 32'h0,        1, 1, 32'h500, 0, 32'h11111111, 1);
    tbl[20] = mk(32'h500, 1, 1, 32'h99,       1, 1, 32'h500, 0, 32'h11111111, 0);
    tbl[21] = mk(32'h500, 0, 0, 32'h0,        1, 1, 32'h500, 0, 32'h11111111, 0);
    tbl[22] = mk(32'h500, 0, 1, 32'h55,       1, 0, 32'h500, 0, 32'h11111111, 0);
    tbl[23] = mk(32'h504, 1, 0, 32'h0,        1, 1, 32'h504, 1, 32'h55,       0);
    tbl[24] = mk(32'h504, 1, 0, 32'h0,        1, 1, 32'h504, 0, 32'h55,       0);

    rst_n_i    = 1'b0;
    im_addr_i  = 32'h0;
    im_flush_i = 1'b0;
    ib.stall   = 1'b1;
    ib.ack     = 1'b0;
    ib.dat     = 32'h0;
    #12;
    checkOutput("reset", 0, 0, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(tbl[i].addr, 1'b0, tbl[i].stall, tbl[i].ack, tbl[i].dat);
      @(negedge clk_i);
      checkOutput($sformatf("vec%0d", i), tbl[i].cyc, tbl[i].stb, 1, tbl[i].adr,
                  tbl[i].valid, tbl[i].data, tbl[i].tmo);
    end

    // Reset asserted while a transfer is outstanding, then a late ack.
    applyStimulus(32'h600, 0, 0, 0, 32'h0);
    @(negedge clk_i);
    checkOutput("rst_pre_idle", 1, 1, 1, 32'h600, 0, 32'h55, 0);
    @(posedge clk_i);
    #1;
    checkOutput("rst_wait", 1, 0, 1, 32'h600, 0, 32'h55, 0);
    #2;
    rst_n_i = 1'b0;
    #1;
    checkOutput("rst_async_cyc", 0, 0, 0, 32'h0, 0, 32'h0, 0);
    ib.ack = 1'b1;
    ib.dat = 32'h77;
    @(posedge clk_i);
    @(negedge clk_i);
    ib.stall = 1'b1;
    rst_n_i  = 1'b1;
    applyStimulus(32'h600, 0, 1, 0, 32'h0);
    @(negedge clk_i);
    checkOutput("rst_late_ack", 1, 1, 1, 32'h600, 0, 32'h0, 0);
    applyStimulus(32'h600, 0, 1, 0, 32'h0);
    @(negedge clk_i);
    checkOutput("rst_late_ack2", 1, 1, 1, 32'h600, 0, 32'h0, 0);

    // Deliver 0x300, then re-present it.
    applyStimulus(32'h300, 0, 0, 0, 32'h0);
    @(negedge clk_i);
    checkOutput("fetch300_stb", 1, 1, 1, 32'h300, 0, 32'h0, 0);
    applyStimulus(32'h300, 0, 0, 1, 32'h1234ABCD);
    @(negedge clk_i);
    checkOutput("fetch300_ack", 1, 0, 1, 32'h300, 0, 32'h0, 0);
`ifdef URV_IMEM_HIT_BUF_EN
    applyStimulus(32'h300, 0, 0, 0, 32'h0);
    @(negedge clk_i);
    checkOutput("hit_first", 0, 0, 0, 32'h0, 1, 32'h1234ABCD, 0);
    applyStimulus(32'h300, 0, 0, 0, 32'h0);
    @(negedge clk_i);
    checkOutput("hit_second", 0, 0, 0, 32'h0, 1, 32'h1234ABCD, 0);
    applyStimulus(32'h300, 1, 1, 0, 32'h0);
    @(negedge clk_i);
    checkOutput("flush_suppress", 1, 1, 1, 32'h300, 1, 32'h1234ABCD, 0);
    applyStimulus(32'h300, 0, 1, 0, 32'h0);
    @(negedge clk_i);
    checkOutput("after_flush", 1, 1, 1, 32'h300, 0, 32'h1234ABCD, 0);
`else
    applyStimulus(32'h300, 1, 1, 0, 32'h0);
    @(negedge clk_i);
    checkOutput("repeat_to_bus", 1, 1, 1, 32'h300, 1, 32'h1234ABCD, 0);
    applyStimulus(32'h300, 0, 1, 0, 32'h0);
    @(negedge clk_i);
    checkOutput("repeat_single_pulse", 1, 1, 1, 32'h300, 0, 32'h1234ABCD, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
